// File: rtl/mips_pkg.sv
// mips_pkg: shared types, widths and access checks for the MIPS memory/write-back stage.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WB} state_t;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  // Misaligned, out of range, or simultaneous read and write.
  function automatic logic is_bad_access(input logic [31:0] addr, input logic rd, input logic wr,
                                         input logic [31:0] depth);
    return ((rd | wr) && (addr[1:0] != 2'd0 || addr > depth - 32'd4)) || (rd && wr);
  endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: byte-addressed big-endian memory with a synchronous word write and async word read.
module data_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int k = 0; k < 4; k++) mem[waddr + AW'(k)] <= wdata[31-8*k -: 8];
  assign rdata = {mem[raddr], mem[raddr + AW'(1)], mem[raddr + AW'(2)], mem[raddr + AW'(3)]};
endmodule

// File: rtl/data_mem_writeback.sv
// data_mem_writeback: MIPS memory-access and write-back stage with a local data memory.
module data_mem_writeback #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_W-1:0]              ALUOut,
  input  logic [DATA_W-1:0]              B,
  input  logic [mips_pkg::REG_ADDR_W-1:0] WriteReg_in,
  input  logic                           MemRead,
  input  logic                           MemWrite,
  input  logic                           MemtoReg,
  input  logic                           RegWrite_in,
  output logic                           wb_valid,
  output logic [DATA_W-1:0]              WriteData,
  output logic [mips_pkg::REG_ADDR_W-1:0] WriteReg,
  output logic                           RegWrite,
  output logic                           mem_err
);
  import mips_pkg::*;
  localparam int AW = $clog2(DEPTH);
  state_t                  state;
  logic [ADDR_W-1:0]       cap_alu;
  logic [REG_ADDR_W-1:0]   cap_reg;
  logic                    cap_mtr, cap_rw, hs, bad;
  logic [DATA_W-1:0]       rdata;
  assign hs  = in_valid & in_ready;
  assign bad = is_bad_access(32'(ALUOut), MemRead, MemWrite, 32'(DEPTH));
  // Stores commit on the handshake edge so the memory is current before any later load.
  data_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk  (CLK),
    .we   (hs & MemWrite & ~bad),
    .waddr(ALUOut[AW-1:0]),
    .wdata(B),
    .raddr(cap_alu[AW-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      wb_valid  <= 1'b0;
      WriteData <= '0;
      WriteReg  <= '0;
      RegWrite  <= 1'b0;
      mem_err   <= 1'b0;
      cap_alu   <= '0;
      cap_reg   <= '0;
      cap_mtr   <= 1'b0;
      cap_rw    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          cap_alu  <= ALUOut;
          cap_reg  <= WriteReg_in;
          cap_mtr  <= MemtoReg;
          cap_rw   <= RegWrite_in;
          in_ready <= 1'b0;
          if (MemRead && !bad) state <= LOAD;
          else begin
            state     <= WB;
            wb_valid  <= 1'b1;
            WriteData <= MemtoReg ? '0 : ALUOut;
            WriteReg  <= WriteReg_in;
            RegWrite  <= RegWrite_in & ~bad & ~MemWrite;
            mem_err   <= bad;
          end
        end
        LOAD: begin
          state     <= WB;
          wb_valid  <= 1'b1;
          WriteData <= cap_mtr ? rdata : cap_alu;
          WriteReg  <= cap_reg;
          RegWrite  <= cap_rw;
        end
        WB: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_writeback.sv
// tb_data_mem_writeback: directed vector table plus hand-written throughput and reset sequences.
module tb_data_mem_writeback;
  import mips_pkg::*;
  localparam int DEPTH = 1024;
  logic        CLK = 0, RESET_N = 1, in_valid = 0;
  logic        in_ready, MemRead = 0, MemWrite = 0, MemtoReg = 0, RegWrite_in = 0;
  logic [31:0] ALUOut = 0, B = 0;
  logic [4:0]  WriteReg_in = 0;
  logic        wb_valid, RegWrite, mem_err;
  logic [31:0] WriteData;
  logic [4:0]  WriteReg;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  data_mem_writeback #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOut(ALUOut), .B(B), .WriteReg_in(WriteReg_in), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite_in(RegWrite_in),
    .wb_valid(wb_valid), .WriteData(WriteData), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .mem_err(mem_err)
  );
  typedef struct {
    logic [31:0] alu, b;
    logic [4:0]  wreg;
    logic        mr, mw, mtr, rw;
    logic [31:0] e_data;
    logic [4:0]  e_reg;
    logic        e_rw, e_err;
    int          e_lat;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b exp 1", in_ready);
    end
  endtask
  task automatic drive(input vec_t t);
    ALUOut = t.alu; B = t.b; WriteReg_in = t.wreg;
    MemRead = t.mr; MemWrite = t.mw; MemtoReg = t.mtr; RegWrite_in = t.rw;
    in_valid = 1;
  endtask
  task automatic run_op(input vec_t t, output logic [31:0] d, output logic [4:0] r,
                        output logic rw, output logic err, output int lat);
    wait_ready();
    drive(t);
    @(posedge CLK); #1;
    in_valid = 0; MemRead = 0; MemWrite = 0;
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 6) begin
      @(posedge CLK); #1;
      lat++;
    end
    d = WriteData; r = WriteReg; rw = RegWrite; err = mem_err;
  endtask
  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    logic        rw, err;
    int          lat, nwb, idx, cnt;
    int          hs_c[3];
    logic        hs_now;
    logic [31:0] alus[3];
    logic [4:0]  regs[3];
    vec_t        t;
    //       alu        b             wreg mr mw mtr rw  e_data        e_reg rw err lat
    v[0]  = '{32'd7,    32'h0,        5'd2, 0, 0, 0, 1, 32'd7,        5'd2, 1, 0, 1};
    v[1]  = '{32'd8,    32'hDEADBEEF, 5'd3, 0, 1, 0, 1, 32'd8,        5'd3, 0, 0, 1};
    v[2]  = '{32'd8,    32'h0,        5'd5, 1, 0, 1, 1, 32'hDEADBEEF, 5'd5, 1, 0, 2};
    v[3]  = '{32'd0,    32'hA5A5A5A5, 5'd0, 0, 1, 0, 0, 32'd0,        5'd0, 0, 0, 1};
    v[4]  = '{32'd1020, 32'h5A5A5A5A, 5'd4, 0, 1, 0, 0, 32'd1020,     5'd4, 0, 0, 1};
    v[5]  = '{32'h6,    32'h0,        5'd7, 1, 0, 0, 1, 32'h6,        5'd7, 0, 1, 1};
    v[6]  = '{32'd1024, 32'hFFFFFFFF, 5'd8, 0, 1, 0, 1, 32'd1024,     5'd8, 0, 1, 1};
    v[7]  = '{32'd0,    32'h12345678, 5'd9, 1, 1, 0, 1, 32'd0,        5'd9, 0, 1, 1};
    v[8]  = '{32'd0,    32'h0,        5'd10,1, 0, 1, 1, 32'hA5A5A5A5, 5'd10,1, 0, 2};
    v[9]  = '{32'd1020, 32'h0,        5'd11,1, 0, 1, 1, 32'h5A5A5A5A, 5'd11,1, 0, 2};
    v[10] = '{32'h40,   32'h0,        5'd12,0, 0, 1, 1, 32'd0,        5'd12,1, 0, 1};
    v[11] = '{32'h123,  32'h0,        5'd0, 0, 0, 0, 1, 32'h123,      5'd0, 1, 0, 1};
    v[12] = '{32'd10,   32'h0,        5'd13,0, 1, 0, 0, 32'd10,       5'd13,0, 1, 1};
    v[13] = '{32'd8,    32'h0,        5'd14,1, 0, 1, 1, 32'hDEADBEEF, 5'd14,1, 0, 2};
    v[14] = '{32'd1024, 32'h0,        5'd15,1, 0, 0, 1, 32'd1024,     5'd15,0, 1, 1};
    #1 RESET_N = 0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    chk("rst in_ready", in_ready, 1);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst RegWrite", RegWrite, 0);
    chk("rst mem_err", mem_err, 0);
    chk("rst WriteData", WriteData, 0);
    chk("rst WriteReg", 32'(WriteReg), 0);
    for (int i = 0; i < 15; i++) begin
      run_op(v[i], d, r, rw, err, lat);
      chk($sformatf("v%0d data", i), d, v[i].e_data);
      chk($sformatf("v%0d reg", i), 32'(r), 32'(v[i].e_reg));
      chk($sformatf("v%0d regwrite", i), 32'(rw), 32'(v[i].e_rw));
      chk($sformatf("v%0d mem_err", i), 32'(err), 32'(v[i].e_err));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].e_lat));
    end
    chk("mem8", 32'(dut.u_mem.mem[8]), 32'hDE);
    chk("mem11", 32'(dut.u_mem.mem[11]), 32'hEF);
    chk("mem0 kept", 32'(dut.u_mem.mem[0]), 32'hA5);
    chk("mem1023 kept", 32'(dut.u_mem.mem[1023]), 32'h5A);
    // back-to-back ALU ops with in_valid held high
    alus = '{32'd100, 32'd200, 32'd300};
    regs = '{5'd1, 5'd2, 5'd3};
    hs_c = '{-10, -10, -10};
    wait_ready();
    t = v[0];
    t.alu = alus[0]; t.wreg = regs[0];
    drive(t);
    idx = 0; nwb = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      hs_now = in_valid && in_ready;
      if (hs_now) hs_c[idx] = c;
      if (wb_valid) begin
        if (nwb < 3) begin
          chk($sformatf("burst%0d data", nwb), WriteData, alus[nwb]);
          chk($sformatf("burst%0d reg", nwb), 32'(WriteReg), 32'(regs[nwb]));
        end
        nwb++;
      end
      @(posedge CLK); #1;
      if (hs_now) begin
        idx++;
        if (idx < 3) begin
          t.alu = alus[idx]; t.wreg = regs[idx];
          drive(t);
        end else in_valid = 0;
      end
    end
    chk("burst gap01", 32'(hs_c[1] - hs_c[0]), 2);
    chk("burst gap12", 32'(hs_c[2] - hs_c[1]), 2);
    chk("burst wb count", 32'(nwb), 3);
    // reset while in LOAD drops the op but keeps the committed store
    t = '{32'd4, 32'h11223344, 5'd0, 0, 1, 0, 0, 32'd0, 5'd0, 0, 0, 1};
    run_op(t, d, r, rw, err, lat);
    chk("st4 mem_err", 32'(err), 0);
    wait_ready();
    t = '{32'd4, 32'h0, 5'd6, 1, 0, 1, 1, 32'd0, 5'd0, 0, 0, 2};
    drive(t);
    @(posedge CLK); #1;
    in_valid = 0; MemRead = 0;
    chk("mid state LOAD", 32'(dut.state), 32'(LOAD));
    #2 RESET_N = 0;
    #1;
    chk("rst state IDLE", 32'(dut.state), 32'(IDLE));
    chk("rst mid in_ready", in_ready, 1);
    chk("rst mid wb_valid", wb_valid, 0);
    cnt = 0;
    @(negedge CLK);
    RESET_N = 1;
    repeat (4) begin
      @(posedge CLK); #1;
      if (wb_valid) cnt++;
    end
    chk("dropped wb count", 32'(cnt), 0);
    run_op(t, d, r, rw, err, lat);
    chk("reload4 data", d, 32'h11223344);
    chk("reload4 regwrite", 32'(rw), 1);
    chk("reload4 latency", 32'(lat), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
